// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB slave registers: word offsets, STATUS layout,
// CTRL bit positions and the slave FSM state encoding.
package opb_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORD_W = 6;
  localparam int unsigned CNT_W  = 16;

  localparam logic [WORD_W-1:0] OFF_DATA   = 6'd0;
  localparam logic [WORD_W-1:0] OFF_STATUS = 6'd1;
  localparam logic [WORD_W-1:0] OFF_CTRL   = 6'd2;

  localparam int unsigned CTRL_CLEAR_BIT  = 0;
  localparam int unsigned CTRL_FREEZE_BIT = 1;

  // STATUS word as seen by software, MSB first
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [13:0]      rsvd;
    logic             overflow;
    logic             new_data;
  } status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT
  } opb_state_e;

  // Byte offset within the window to 32-bit word index
  function automatic logic [WORD_W-1:0] byte_to_word(input logic [7:0] byte_off);
    return WORD_W'(byte_off >> 2);
  endfunction

endpackage

// File: rtl/opb_slave_if.sv
// Generic OPB slave front end: window decode, IDLE/ACK/WAIT handshake,
// registered ack and read data that is zero outside the ack cycle.
module opb_slave_if
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01000600,
  parameter logic [31:0] C_HIGHADDR = 32'h010006FF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_i,
  input  logic              rnw_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [WORD_W-1:0] word_c_o,
  output logic              rd_stb_c_o,
  output logic              wr_stb_c_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] dbus_o
);

  opb_state_e        state_q, state_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] dbus_q, dbus_d;
  logic              ack_q, ack_d;
  logic              in_win_c;
  logic              dec_c;

  assign in_win_c   = sel_i && (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);
  assign dec_c      = (state_q == ST_IDLE) && in_win_c;
  assign word_c_o   = byte_to_word(addr_i[7:0]);
  assign rd_stb_c_o = dec_c && rnw_i;
  assign wr_stb_c_o = dec_c && !rnw_i;

  // Next state; dbus is only driven in the cycle that carries the ack
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    ack_d   = 1'b0;
    dbus_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_win_c) begin
          rd_d    = rnw_i ? rdata_i : '0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_d   = 1'b1;
        dbus_d  = rd_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!sel_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      dbus_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      dbus_q  <= dbus_d;
    end
  end

  assign ack_o  = ack_q;
  assign dbus_o = dbus_q;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave register carrying words from user logic to the PPC, with sticky
// new-data / overflow flags, a saturating capture count and a freeze control.
module opb_register_simulink2ppc
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01000600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010006FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_valid
);

  if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_width
    $error("opb_register_simulink2ppc supports only a 32-bit OPB");
  end
  if (C_FAMILY == "") begin : g_no_family
    $error("opb_register_simulink2ppc needs a target family");
  end

  // Bus bit 0 is the MSB, so a plain assignment maps it onto bit 31
  logic [DATA_W-1:0] abus_c, wdata_c, rdata_c, dbus_c;
  logic [WORD_W-1:0] word_c;
  logic              rd_stb_c, wr_stb_c, ack_c;
  logic              unused_c;

  assign abus_c  = OPB_ABus;
  assign wdata_c = OPB_DBus;
  assign unused_c = ^{OPB_BE, OPB_seqAddr, wdata_c[DATA_W-1:2]};

  logic [DATA_W-1:0] data_q, data_d;
  logic              new_q, new_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              freeze_q, freeze_d;
  status_t           status_c;

  opb_slave_if #(
    .C_BASEADDR(C_BASEADDR),
    .C_HIGHADDR(C_HIGHADDR)
  ) u_slave (
    .clk_i     (OPB_Clk),
    .rst_i     (OPB_Rst),
    .sel_i     (OPB_select),
    .rnw_i     (OPB_RNW),
    .addr_i    (abus_c),
    .rdata_i   (rdata_c),
    .word_c_o  (word_c),
    .rd_stb_c_o(rd_stb_c),
    .wr_stb_c_o(wr_stb_c),
    .ack_o     (ack_c),
    .dbus_o    (dbus_c)
  );

  always_comb begin
    status_c          = '0;
    status_c.count    = cnt_q;
    status_c.overflow = ovf_q;
    status_c.new_data = new_q;
  end

  always_comb begin
    rdata_c = '0;
    case (word_c)
      OFF_DATA:   rdata_c = data_q;
      OFF_STATUS: rdata_c = status_c;
      OFF_CTRL:   rdata_c[CTRL_FREEZE_BIT] = freeze_q;
      default:    rdata_c = '0;
    endcase
  end

  // Ordering: read side-effect, then CTRL write, then capture (capture wins)
  always_comb begin
    data_d   = data_q;
    new_d    = new_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    freeze_d = freeze_q;
    if (rd_stb_c && word_c == OFF_DATA) new_d = 1'b0;
    if (wr_stb_c && word_c == OFF_CTRL) begin
      freeze_d = wdata_c[CTRL_FREEZE_BIT];
      if (wdata_c[CTRL_CLEAR_BIT]) begin
        new_d = 1'b0;
        ovf_d = 1'b0;
        cnt_d = '0;
      end
    end
    if (user_valid && !freeze_q) begin
      data_d = user_data_in;
      if (new_d) ovf_d = 1'b1;
      new_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q   <= '0;
      new_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      freeze_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      new_q    <= new_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      freeze_q <= freeze_d;
    end
  end

  assign Sl_DBus    = dbus_c;
  assign Sl_xferAck = ack_c;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: OPB reads/writes with
// hand-computed expected register values.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] A_DATA = 32'h01000600;
  localparam logic [31:0] A_STAT = 32'h01000604;
  localparam logic [31:0] A_CTRL = 32'h01000608;
  localparam logic [31:0] A_OUT  = 32'h01000700;

  logic        clk = 1'b0;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_valid;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic bus_leak = 1'b0;
  logic last_msb = 1'b0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (OPB_Rst),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .Sl_DBus     (Sl_DBus),
    .Sl_xferAck  (Sl_xferAck),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .user_data_in(user_data_in),
    .user_valid  (user_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One OPB beat with optional capture in the decode cycle; lat = 0 on timeout
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic cap, input logic [31:0] cap_word,
                      output logic [31:0] data, output int lat);
    @(posedge clk); #1;
    OPB_select   = 1'b1;
    OPB_RNW      = rnw;
    OPB_ABus     = addr;
    OPB_DBus     = rnw ? 32'h0 : wdata;
    user_valid   = cap;
    user_data_in = cap_word;
    lat  = 0;
    data = 32'h0;
    for (int n = 1; n <= 16 && lat == 0; n++) begin
      @(posedge clk); #1;
      user_valid = 1'b0;
      if (Sl_xferAck) begin
        lat      = n;
        data     = Sl_DBus;
        last_msb = Sl_DBus[0];
      end else if (Sl_DBus != 0) begin
        bus_leak = 1'b1;
      end
    end
    OPB_select = 1'b0;
    OPB_RNW    = 1'b0;
    OPB_DBus   = 32'h0;
    @(posedge clk); #1;
    if (Sl_xferAck || Sl_DBus != 0) bus_leak = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int          l;
    xfer(1'b1, addr, 32'h0, 1'b0, 32'h0, d, l);
    check({tag, "_lat"}, 32'(l), 32'd2);
    check(tag, d, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic cap, input logic [31:0] cap_word);
    logic [31:0] d;
    int          l;
    xfer(1'b0, addr, wdata, cap, cap_word, d, l);
    check({tag, "_lat"}, 32'(l), 32'd2);
  endtask

  task automatic capture(input logic [31:0] w);
    @(posedge clk); #1;
    user_valid   = 1'b1;
    user_data_in = w;
    @(posedge clk); #1;
    user_valid   = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          l;
    logic        seen;
    OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = 4'hF; OPB_DBus = '0; OPB_RNW = 1'b0;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 OPB_Rst = 1'b0;
    check("rst_ack", 32'(Sl_xferAck), 32'd0);
    check("rst_dbus", Sl_DBus, 32'h0);
    check("const_outs", 32'({Sl_errAck, Sl_retry, Sl_toutSup}), 32'd0);

    rd_chk("t1_data", A_DATA, 32'h0);
    check("t1_leak", 32'(bus_leak), 32'd0);

    capture(32'hDEADBEEF);
    rd_chk("t2_stat", A_STAT, 32'h00010001);
    rd_chk("t2_data", A_DATA, 32'hDEADBEEF);
    check("t2_msb", 32'(last_msb), 32'd1);
    rd_chk("t2_stat2", A_STAT, 32'h00010000);

    wr("t3_pre", A_CTRL, 32'h1, 1'b0, 32'h0);
    capture(32'h1);
    capture(32'h2);
    rd_chk("t3_stat", A_STAT, 32'h00020003);
    wr("t3_clr", A_CTRL, 32'h1, 1'b0, 32'h0);
    rd_chk("t3_stat2", A_STAT, 32'h0);

    capture(32'h2A);
    rd_chk("t4_stat", A_STAT, 32'h00010001);
    xfer(1'b1, A_DATA, 32'h0, 1'b1, 32'h55, d, l);
    check("t4_rdcap", d, 32'h2A);
    xfer(1'b1, A_STAT, 32'h0, 1'b0, 32'h0, d, l);
    check("t4_rdcap_stat", d & 32'hFFFF0001, 32'h00020001);
    rd_chk("t4_data", A_DATA, 32'h55);
    wr("t4_clrcap", A_CTRL, 32'h1, 1'b1, 32'h66);
    rd_chk("t4_clrcap_stat", A_STAT, 32'h00010001);

    wr("t5_frz", A_CTRL, 32'h2, 1'b1, 32'h70);
    capture(32'h77);
    rd_chk("t5_data", A_DATA, 32'h70);
    rd_chk("t5_stat", A_STAT, 32'h00020002);
    rd_chk("t5_ctrl", A_CTRL, 32'h2);

    // Out-of-window select must never be acknowledged
    @(posedge clk); #1;
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = A_OUT;
    seen = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
      if (Sl_xferAck) seen = 1'b1;
      if (Sl_DBus != 0) bus_leak = 1'b1;
    end
    OPB_select = 1'b0;
    check("t6_oow_ack", 32'(seen), 32'd0);

    // Reset while the FSM sits in ACK
    @(posedge clk); #1;
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = A_DATA;
    @(posedge clk); #1;
    OPB_Rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_ack", 32'(Sl_xferAck), 32'd0);
    OPB_Rst = 1'b0; OPB_select = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_ack2", 32'(Sl_xferAck), 32'd0);
    rd_chk("t6_rst_data", A_DATA, 32'h0);
    rd_chk("t6_rst_stat", A_STAT, 32'h0);
    rd_chk("t6_rst_ctrl", A_CTRL, 32'h0);

    @(posedge clk); #1;
    user_valid = 1'b1; user_data_in = 32'h12345678;
    repeat (70000) @(posedge clk);
    #1 user_valid = 1'b0;
    rd_chk("t6_sat_stat", A_STAT, 32'hFFFF0003);
    rd_chk("t6_sat_data", A_DATA, 32'h12345678);

    check("leak_final", 32'(bus_leak), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
